// File: rtl/modexp_sequencer_if.sv
// Command, status and Montgomery-multiplier signals of modexp_sequencer.
// slave = the sequencer; master = command FSM plus the two multiplier cores.
interface modexp_sequencer_if #(
  parameter int DATA_W = 1024,
  parameter int EXP_W  = 1024,
  parameter int LEN_W  = 11
);
  logic              start;
  logic [DATA_W-1:0] x, r2n, rn, n;
  logic [EXP_W-1:0]  e;
  logic [LEN_W-1:0]  e_len;
  logic              busy, done, error;
  logic [DATA_W-1:0] result;
  logic              mm0_start, mm1_start;
  logic [DATA_W-1:0] mm0_a, mm0_b, mm1_a, mm1_b, mm0_m, mm1_m;
  logic [DATA_W-1:0] mm0_result, mm1_result;
  logic              mm0_done, mm1_done;

  modport slave (
    input  start, x, r2n, rn, n, e, e_len, mm0_result, mm1_result, mm0_done, mm1_done,
    output busy, done, error, result, mm0_start, mm1_start,
           mm0_a, mm0_b, mm1_a, mm1_b, mm0_m, mm1_m
  );
  modport master (
    output start, x, r2n, rn, n, e, e_len, mm0_result, mm1_result, mm0_done, mm1_done,
    input  busy, done, error, result, mm0_start, mm1_start,
           mm0_a, mm0_b, mm1_a, mm1_b, mm0_m, mm1_m
  );
endinterface

// File: rtl/modexp_sequencer.sv
// Modular exponentiation sequencer driving external Montgomery multipliers.
// Define MODEXP_LADDER_EN for the constant-time two-multiplier Montgomery ladder.
module modexp_sequencer #(
  parameter int DATA_W = 1024,
  parameter int EXP_W  = 1024,
  parameter int LEN_W  = 11
) (
  input  logic               clk,
  input  logic               reset,
  modexp_sequencer_if.slave  bus
);
  localparam int IDX_W = $clog2(EXP_W);
  localparam logic [DATA_W-1:0] DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]  IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

`ifdef MODEXP_LADDER_EN
  typedef enum logic [2:0] {IDLE, TOMONT, LADDER, FROMMONT, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, TOMONT, SQ, MUL, FROMMONT, DONE} state_t;
`endif

  state_t            state_r, state_n;
  logic [LEN_W-1:0]  idx_r, idx_n;
  logic [EXP_W-1:0]  e_r, e_n;
  logic [DATA_W-1:0] n_r, n_n;
  // r0 holds A (or ladder R0); r1 holds Xt (or ladder R1).
  logic [DATA_W-1:0] r0_r, r0_n, r1_r, r1_n;
  logic [DATA_W-1:0] mm0_a_r, mm0_a_n, mm0_b_r, mm0_b_n, result_r, result_n;
  logic              mm0_start_r, mm0_start_n;
  logic              busy_r, busy_n, done_r, done_n, error_r, error_n;
  logic [IDX_W-1:0]  bit_idx_s;
  logic              e_bit_s;

  assign bit_idx_s = idx_r[IDX_W-1:0];
  assign e_bit_s   = e_r[bit_idx_s];

`ifdef MODEXP_LADDER_EN
  logic [DATA_W-1:0] mm1_a_r, mm1_a_n, mm1_b_r, mm1_b_n;
  logic              mm1_start_r, mm1_start_n, f0_r, f0_n, f1_r, f1_n;
  logic              e_next_s;
  assign e_next_s = e_r[bit_idx_s - IDX_ONE];
`endif

  // Next-state and next-register values; defaults hold every register.
  always_comb begin
    state_n     = state_r;
    idx_n       = idx_r;
    e_n         = e_r;
    n_n         = n_r;
    r0_n        = r0_r;
    r1_n        = r1_r;
    mm0_a_n     = mm0_a_r;
    mm0_b_n     = mm0_b_r;
    mm0_start_n = 1'b0;
    busy_n      = busy_r;
    done_n      = 1'b0;
    error_n     = error_r;
    result_n    = result_r;
`ifdef MODEXP_LADDER_EN
    mm1_a_n     = mm1_a_r;
    mm1_b_n     = mm1_b_r;
    mm1_start_n = 1'b0;
    f0_n        = f0_r;
    f1_n        = f1_r;
`endif
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          n_n      = bus.n;
          e_n      = bus.e;
          idx_n    = bus.e_len - LEN_ONE;
          r0_n     = bus.rn;
          error_n  = 1'b0;
          result_n = '0;
          busy_n   = 1'b1;
          if ((bus.e_len == '0) || (bus.e_len > LEN_W'(EXP_W))) begin
            state_n = DONE;
            done_n  = 1'b1;
            error_n = 1'b1;
          end else begin
            state_n     = TOMONT;
            mm0_start_n = 1'b1;
            mm0_a_n     = bus.x;
            mm0_b_n     = bus.r2n;
          end
        end else begin
          state_n = IDLE;
        end
      end
      TOMONT: begin
        if (bus.mm0_done) begin
          r1_n        = bus.mm0_result;
          mm0_start_n = 1'b1;
`ifdef MODEXP_LADDER_EN
          state_n     = LADDER;
          mm0_a_n     = r0_r;
          mm0_b_n     = bus.mm0_result;
          mm1_start_n = 1'b1;
          mm1_a_n     = e_bit_s ? bus.mm0_result : r0_r;
          mm1_b_n     = e_bit_s ? bus.mm0_result : r0_r;
`else
          state_n     = SQ;
          mm0_a_n     = r0_r;
          mm0_b_n     = r0_r;
`endif
        end else begin
          state_n = TOMONT;
        end
      end
`ifdef MODEXP_LADDER_EN
      LADDER: begin
        if (bus.mm0_done && !f0_r) begin
          f0_n = 1'b1;
          if (e_bit_s) r0_n = bus.mm0_result;
          else         r1_n = bus.mm0_result;
        end else begin
          f0_n = f0_r;
        end
        if (bus.mm1_done && !f1_r) begin
          f1_n = 1'b1;
          if (e_bit_s) r1_n = bus.mm1_result;
          else         r0_n = bus.mm1_result;
        end else begin
          f1_n = f1_r;
        end
        // Advance on the edge that completes the pair, so the next start follows the later done.
        if (f0_n && f1_n) begin
          f0_n        = 1'b0;
          f1_n        = 1'b0;
          mm0_start_n = 1'b1;
          mm0_a_n     = r0_n;
          if (idx_r == '0) begin
            state_n = FROMMONT;
            mm0_b_n = DATA_ONE;
          end else begin
            idx_n       = idx_r - LEN_ONE;
            mm0_b_n     = r1_n;
            mm1_start_n = 1'b1;
            mm1_a_n     = e_next_s ? r1_n : r0_n;
            mm1_b_n     = e_next_s ? r1_n : r0_n;
          end
        end else begin
          state_n = LADDER;
        end
      end
`else
      SQ, MUL: begin
        if (bus.mm0_done) begin
          r0_n        = bus.mm0_result;
          mm0_start_n = 1'b1;
          mm0_a_n     = bus.mm0_result;
          if ((state_r == SQ) && e_bit_s) begin
            state_n = MUL;
            mm0_b_n = r1_r;
          end else if (idx_r == '0) begin
            state_n = FROMMONT;
            mm0_b_n = DATA_ONE;
          end else begin
            state_n = SQ;
            idx_n   = idx_r - LEN_ONE;
            mm0_b_n = bus.mm0_result;
          end
        end else begin
          state_n = state_r;
        end
      end
`endif
      FROMMONT: begin
        if (bus.mm0_done) begin
          result_n = bus.mm0_result;
          done_n   = 1'b1;
          state_n  = DONE;
        end else begin
          state_n = FROMMONT;
        end
      end
      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      e_r         <= '0;
      n_r         <= '0;
      r0_r        <= '0;
      r1_r        <= '0;
      mm0_a_r     <= '0;
      mm0_b_r     <= '0;
      mm0_start_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      result_r    <= '0;
`ifdef MODEXP_LADDER_EN
      mm1_a_r     <= '0;
      mm1_b_r     <= '0;
      mm1_start_r <= 1'b0;
      f0_r        <= 1'b0;
      f1_r        <= 1'b0;
`endif
    end else begin
      state_r     <= state_n;
      idx_r       <= idx_n;
      e_r         <= e_n;
      n_r         <= n_n;
      r0_r        <= r0_n;
      r1_r        <= r1_n;
      mm0_a_r     <= mm0_a_n;
      mm0_b_r     <= mm0_b_n;
      mm0_start_r <= mm0_start_n;
      busy_r      <= busy_n;
      done_r      <= done_n;
      error_r     <= error_n;
      result_r    <= result_n;
`ifdef MODEXP_LADDER_EN
      mm1_a_r     <= mm1_a_n;
      mm1_b_r     <= mm1_b_n;
      mm1_start_r <= mm1_start_n;
      f0_r        <= f0_n;
      f1_r        <= f1_n;
`endif
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.error     = error_r;
  assign bus.result    = result_r;
  assign bus.mm0_start = mm0_start_r;
  assign bus.mm0_a     = mm0_a_r;
  assign bus.mm0_b     = mm0_b_r;
  assign bus.mm0_m     = n_r;
  assign bus.mm1_m     = n_r;
`ifdef MODEXP_LADDER_EN
  assign bus.mm1_start = mm1_start_r;
  assign bus.mm1_a     = mm1_a_r;
  assign bus.mm1_b     = mm1_b_r;
`else
  logic unused_s;
  assign unused_s      = ^{bus.mm1_result, bus.mm1_done};
  assign bus.mm1_start = 1'b0;
  assign bus.mm1_a     = '0;
  assign bus.mm1_b     = '0;
`endif
endmodule

// File: tb/tb_modexp_sequencer.sv
// Self-checking bench for modexp_sequencer with behavioural Montgomery multipliers.
// Expected results come from plain modular exponentiation; latency from the op-count rules.
module tb_modexp_sequencer;
  localparam int DW = 8;
  localparam int EW = 16;
  localparam int LW = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   lat0   = 3;
  int   lat1   = 3;

  modexp_sequencer_if #(.DATA_W(DW), .EXP_W(EW), .LEN_W(LW)) bus ();
  modexp_sequencer #(.DATA_W(DW), .EXP_W(EW), .LEN_W(LW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // a*b*R^-1 mod m with R = 256
  function automatic logic [7:0] mont(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
    int mi;
    int rinv;
    mi   = int'(m);
    rinv = 0;
    if (mi < 2) return 8'd0;
    for (int r = 1; r < 256; r++) begin
      if ((256 * r) % mi == 1) begin
        rinv = r;
        break;
      end
    end
    return 8'((((int'(a) * int'(b)) % mi) * rinv) % mi);
  endfunction

  function automatic int modpow(input int xv, input logic [15:0] ev, input int len, input int nv);
    int r;
    int p;
    r = 1 % nv;
    p = xv % nv;
    for (int i = 0; i < len; i++) begin
      if (ev[i]) r = (r * p) % nv;
      p = (p * p) % nv;
    end
    return r;
  endfunction

  function automatic int exp_ops(input logic [15:0] ev, input int len);
    int pc;
    pc = 0;
    for (int i = 0; i < len; i++) pc += int'(ev[i]);
`ifdef MODEXP_LADDER_EN
    return 2 + len;
`else
    return 2 + len + pc;
`endif
  endfunction

  function automatic int exp_cycles(input logic [15:0] ev, input int len);
`ifdef MODEXP_LADDER_EN
    return 1 + 2 * (lat0 + 1) + len * (((lat1 > lat0) ? lat1 : lat0) + 1);
`else
    return 1 + exp_ops(ev, len) * (lat0 + 1);
`endif
  endfunction

  // multiplier 0: fixed latency lat0, done pulse lat0 cycles after the start cycle
  initial begin : mm0_model
    int cnt;
    bit pend;
    logic [7:0] a, b, m;
    pend = 1'b0;
    cnt  = 0;
    bus.mm0_done   = 1'b0;
    bus.mm0_result = '0;
    forever begin
      @(negedge clk);
      bus.mm0_done = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          bus.mm0_done   = 1'b1;
          bus.mm0_result = mont(a, b, m);
          pend = 1'b0;
        end
      end
      if (bus.mm0_start) begin
        a = bus.mm0_a; b = bus.mm0_b; m = bus.mm0_m;
        cnt = lat0; pend = 1'b1;
      end
    end
  end

  // multiplier 1: same behaviour with its own latency lat1
  initial begin : mm1_model
    int cnt;
    bit pend;
    logic [7:0] a, b, m;
    pend = 1'b0;
    cnt  = 0;
    bus.mm1_done   = 1'b0;
    bus.mm1_result = '0;
    forever begin
      @(negedge clk);
      bus.mm1_done = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          bus.mm1_done   = 1'b1;
          bus.mm1_result = mont(a, b, m);
          pend = 1'b0;
        end
      end
      if (bus.mm1_start) begin
        a = bus.mm1_a; b = bus.mm1_b; m = bus.mm1_m;
        cnt = lat1; pend = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int nv, input logic [7:0] xv, input logic [15:0] ev, input logic [4:0] lv);
    bus.n     = 8'(nv);
    bus.rn    = 8'(256 % nv);
    bus.r2n   = 8'(65536 % nv);
    bus.x     = xv;
    bus.e     = ev;
    bus.e_len = lv;
    bus.start = 1'b1;
  endtask

  // Runs one request; cycle 1 is the cycle after the accepting edge.
  task automatic run(input int nv, input logic [7:0] xv, input logic [15:0] ev, input logic [4:0] lv,
                     input bit noise, output int dcyc, output int n0, output int n1,
                     output logic [7:0] res, output logic err, output logic bz_done,
                     output logic bz_after, output logic [7:0] m_seen);
    @(negedge clk);
    drive(nv, xv, ev, lv);
    @(negedge clk);
    bus.start = 1'b0;
    dcyc = -1; n0 = 0; n1 = 0; res = '0; err = 1'b0; bz_done = 1'b0; m_seen = '0;
    for (int k = 1; k <= 3000; k++) begin
      if (bus.mm0_start) n0++;
      if (bus.mm1_start) n1++;
      if (noise) begin
        bus.start = (k >= 3) && (k <= 8);
        bus.x     = 8'($urandom);
      end
      if (bus.done) begin
        dcyc = k; res = bus.result; err = bus.error; bz_done = bus.busy; m_seen = bus.mm0_m;
        break;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    @(negedge clk);
    bz_after = bus.busy;
  endtask

  task automatic do_vec(input string tag, input int nv, input logic [7:0] xv, input logic [15:0] ev,
                        input logic [4:0] lv, input bit noise);
    int dcyc, n0, n1;
    logic [7:0] res, m_seen;
    logic err, bz_done, bz_after;
    bit bad;
    bad = (lv == 5'd0) || (int'(lv) > EW);
    run(nv, xv, ev, lv, noise, dcyc, n0, n1, res, err, bz_done, bz_after, m_seen);
    check({tag, ".result"}, 32'(res), bad ? 32'd0 : 32'(modpow(int'(xv), ev, int'(lv), nv)));
    check({tag, ".error"},  32'(err), bad ? 32'd1 : 32'd0);
    check({tag, ".cycles"}, 32'(dcyc), bad ? 32'd1 : 32'(exp_cycles(ev, int'(lv))));
    check({tag, ".mm0_starts"}, 32'(n0), bad ? 32'd0 : 32'(exp_ops(ev, int'(lv))));
`ifdef MODEXP_LADDER_EN
    check({tag, ".mm1_starts"}, 32'(n1), bad ? 32'd0 : 32'(lv));
`else
    check({tag, ".mm1_starts"}, 32'(n1), 32'd0);
`endif
    check({tag, ".mm_m"}, 32'(m_seen), 32'(nv));
    check({tag, ".busy_at_done"}, 32'(bz_done), 32'd1);
    check({tag, ".busy_after"}, 32'(bz_after), 32'd0);
  endtask

  initial begin
    int stray;
    logic [15:0] ev;
    bus.start = 1'b0; bus.x = '0; bus.r2n = '0; bus.rn = '0; bus.n = '0; bus.e = '0; bus.e_len = '0;
    repeat (3) @(negedge clk);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.error", 32'(bus.error), 32'd0);
    check("rst.result", 32'(bus.result), 32'd0);
    check("rst.mm_start", 32'({bus.mm0_start, bus.mm1_start}), 32'd0);
    reset = 1'b0;

    do_vec("vecA", 23, 8'd5, 16'b1011, 5'd4, 1'b0);
`ifndef MODEXP_LADDER_EN
    check("mm1_tied", 32'({bus.mm1_a, bus.mm1_b}), 32'd0);
`endif
    do_vec("vecB", 23, 8'd30, 16'h0001, 5'd1, 1'b0);
    do_vec("elen0", 23, 8'd5, 16'b1011, 5'd0, 1'b0);
    do_vec("elen_big", 23, 8'd5, 16'b1011, 5'd20, 1'b0);
    do_vec("full16", 23, 8'd7, 16'hA5C3, 5'd16, 1'b0);
    lat1 = 5;
    do_vec("mm1_late", 23, 8'd5, 16'b1011, 5'd4, 1'b0);
    lat1 = 3;
    do_vec("pre_rst", 23, 8'd5, 16'b1011, 5'd4, 1'b0);

    // reset while the first MUL (third op, started in cycle 9) is in flight
    @(negedge clk);
    drive(23, 8'd5, 16'b1011, 5'd4);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmul.busy", 32'(bus.busy), 32'd0);
    check("rstmul.result", 32'(bus.result), 32'd0);
    check("rstmul.mm0_start", 32'(bus.mm0_start), 32'd0);
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.busy || bus.done || bus.mm0_start || bus.mm1_start) stray++;
    end
    check("rstmul.late_done_ignored", 32'(stray), 32'd0);
    do_vec("fresh", 23, 8'd5, 16'b1011, 5'd4, 1'b0);

    do_vec("start_while_busy", 23, 8'd5, 16'b1011, 5'd4, 1'b1);

    for (int i = 0; i < 8; i++) begin
      lat0 = int'($urandom_range(1, 4));
      lat1 = int'($urandom_range(1, 5));
      ev   = 16'($urandom);
      do_vec($sformatf("rand%0d", i), int'($urandom_range(1, 127)) * 2 + 1, 8'($urandom), ev,
             5'($urandom_range(1, 16)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
